controlador_es: RTL and testbench

Controller for the processor's input/output ports, sitting between the board (switches, confirm button, display) and the register bank's `In`/`Out` strobes.
- **Input:** on an input instruction it stalls the processor until the user presses the confirm button. It then delivers the switch value on `Dados_entrada` and pulses `In` for one cycle, so the bank loads register `RE`.
- **Output:** on an output instruction it drives `Out`, captures the bank's `RS` result on the following edge, and holds it for the display with a transfer counter.

---
 rtl/controlador_es_if.sv | 26 ++
 rtl/controlador_es.sv | 149 ++++++++++++++
 tb/tb_controlador_es.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_es_if.sv
// Board/bank-side signal bundle of the I/O port controller.
// The master side is the control unit, board and register bank; the slave side is the controller.
interface controlador_es_if;
  logic        i_entrada_req;
  logic        i_saida_req;
  logic [15:0] i_chaves;
  logic        i_botao_confirma;
  logic [31:0] i_rs;
  logic [31:0] o_dados_entrada;
  logic        o_in;
  logic        o_out;
  logic        o_parar;
  logic [31:0] o_display;
  logic        o_saida_valida;
  logic [7:0]  o_cont_saida;

  modport master (
    output i_entrada_req, i_saida_req, i_chaves, i_botao_confirma, i_rs,
    input  o_dados_entrada, o_in, o_out, o_parar, o_display, o_saida_valida, o_cont_saida
  );

  modport slave (
    input  i_entrada_req, i_saida_req, i_chaves, i_botao_confirma, i_rs,
    output o_dados_entrada, o_in, o_out, o_parar, o_display, o_saida_valida, o_cont_saida
  );
endinterface

// File: rtl/controlador_es.sv
// I/O port controller: stalls input instructions until a debounced confirm press delivers
// the switch value, and captures output instructions' RS value for the display.
module controlador_es #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter bit SINAL           = 1'b1
) (
  input logic             clk,
  input logic             reset,
  controlador_es_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESPERA_LIBERA = 2'd1,
    ESPERA_BOTAO  = 2'd2,
    CONCLUI       = 2'd3
  } estado_t;

  logic          r_btn_s1;
  logic          r_btn_s2;
  logic [15:0]   r_sw_s1;
  logic [15:0]   r_sw_s2;
  logic          r_btn_deb;
  logic [CW-1:0] r_deb_cnt;
  logic          r_pressao;
  estado_t       r_estado;
  logic [31:0]   r_dados;
  logic          r_in;
  logic [31:0]   r_display;
  logic          r_valida;
  logic [7:0]    r_cont;
  logic          w_parar;

  function automatic logic [31:0] estender(input logic [15:0] sw);
    return {{16{SINAL & sw[15]}}, sw};
  endfunction

  // Two-flop synchronizers for the asynchronous button and switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= 16'h0000;
      r_sw_s2  <= 16'h0000;
    end else begin
      r_btn_s1 <= bus.i_botao_confirma;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= bus.i_chaves;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce: level flips after DEBOUNCE_CICLOS consecutive mismatching cycles; pressao marks a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_deb <= 1'b0;
      r_deb_cnt <= '0;
      r_pressao <= 1'b0;
    end else if (r_btn_s2 == r_btn_deb) begin
      r_deb_cnt <= '0;
      r_pressao <= 1'b0;
    end else if (r_deb_cnt == DEB_MAX) begin
      r_btn_deb <= r_btn_s2;
      r_deb_cnt <= '0;
      r_pressao <= r_btn_s2;
    end else begin
      r_deb_cnt <= r_deb_cnt + CW'(1);
      r_pressao <= 1'b0;
    end
  end

  // Input FSM; a button already down at request time must be released before it counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_dados  <= 32'h0000_0000;
      r_in     <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          r_in <= 1'b0;
          if (bus.i_entrada_req) begin
            r_estado <= r_btn_deb ? ESPERA_LIBERA : ESPERA_BOTAO;
          end
        end
        ESPERA_LIBERA: begin
          r_in <= 1'b0;
          if (!bus.i_entrada_req) begin
            r_estado <= OCIOSO;
          end else if (!r_btn_deb) begin
            r_estado <= ESPERA_BOTAO;
          end
        end
        ESPERA_BOTAO: begin
          if (!bus.i_entrada_req) begin
            r_estado <= OCIOSO;
            r_in     <= 1'b0;
          end else if (r_pressao) begin
            r_dados  <= estender(r_sw_s2);
            r_in     <= 1'b1;
            r_estado <= CONCLUI;
          end else begin
            r_in <= 1'b0;
          end
        end
        CONCLUI: begin
          r_in     <= 1'b0;
          r_estado <= OCIOSO;
        end
        default: begin
          r_in     <= 1'b0;
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  // Output capture: RS is valid after the falling edge, so it is sampled at the closing rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_display <= 32'h0000_0000;
      r_valida  <= 1'b0;
      r_cont    <= 8'h00;
    end else if (bus.i_saida_req) begin
      r_display <= bus.i_rs;
      r_valida  <= 1'b1;
      r_cont    <= r_cont + 8'd1;
    end else begin
      r_display <= r_display;
      r_valida  <= r_valida;
      r_cont    <= r_cont;
    end
  end

  assign w_parar = (bus.i_entrada_req && (r_estado == OCIOSO)) ||
                   (r_estado == ESPERA_LIBERA) || (r_estado == ESPERA_BOTAO);

  assign bus.o_dados_entrada = r_dados;
  assign bus.o_in            = r_in;
  assign bus.o_out           = bus.i_saida_req;
  assign bus.o_parar         = w_parar;
  assign bus.o_display       = r_display;
  assign bus.o_saida_valida  = r_valida;
  assign bus.o_cont_saida    = r_cont;

endmodule

// File: tb/tb_controlador_es.sv
// Randomized bench for controlador_es against a transaction-level reference model
// (expected In cycle from press time, arithmetic sign extension, counted output captures).
module tb_controlador_es;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controlador_es_if ifa ();
  controlador_es_if ifz ();

  assign ifz.i_entrada_req    = ifa.i_entrada_req;
  assign ifz.i_saida_req      = ifa.i_saida_req;
  assign ifz.i_chaves         = ifa.i_chaves;
  assign ifz.i_botao_confirma = ifa.i_botao_confirma;
  assign ifz.i_rs             = ifa.i_rs;

  controlador_es #(.DEBOUNCE_CICLOS(DEB), .SINAL(1'b1)) u_dut   (.clk(clk), .reset(reset), .bus(ifa));
  controlador_es #(.DEBOUNCE_CICLOS(DEB), .SINAL(1'b0)) u_dut_z (.clk(clk), .reset(reset), .bus(ifz));

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          exp_in_cyc;
  int          n_in  = 0;
  int          m_cnt;
  logic [31:0] exp_data_s, exp_data_z;
  logic [31:0] m_dados_s, m_dados_z, m_disp;
  logic        m_valid, req_prev;
  logic [31:0] rs, bank_val;
  logic        rand_out;

  assign ifa.i_rs = rs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bank model: RS carries the requested word only after the falling edge of an Out cycle
  always @(negedge clk) rs <= ifa.i_saida_req ? bank_val : $urandom;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state advanced at each rising edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_disp    <= 32'h0;
      m_valid   <= 1'b0;
      m_cnt     <= 0;
      m_dados_s <= 32'h0;
      m_dados_z <= 32'h0;
      req_prev  <= 1'b0;
    end else begin
      req_prev <= ifa.i_entrada_req;
      if (ifa.i_saida_req) begin
        m_disp  <= rs;
        m_valid <= 1'b1;
        m_cnt   <= (m_cnt + 1) % 256;
      end
      if (cyc + 1 == exp_in_cyc) begin
        m_dados_s <= exp_data_s;
        m_dados_z <= exp_data_z;
      end
    end
  end

  task automatic mon();
    logic e_parar;
    logic e_in;
    e_in = (cyc == exp_in_cyc);
    if (e_in) e_parar = 1'b0;
    else      e_parar = ifa.i_entrada_req | (req_prev & (cyc - 1 != exp_in_cyc));
    check_eq("out",     32'(ifa.o_out), 32'(ifa.i_saida_req));
    check_eq("parar",   32'(ifa.o_parar), 32'(e_parar));
    check_eq("in",      32'(ifa.o_in), 32'(e_in));
    check_eq("dados_s", ifa.o_dados_entrada, m_dados_s);
    check_eq("display", ifa.o_display, m_disp);
    check_eq("valida",  32'(ifa.o_saida_valida), 32'(m_valid));
    check_eq("cont",    32'(ifa.o_cont_saida), 32'(m_cnt));
    check_eq("in_z",    32'(ifz.o_in), 32'(e_in));
    check_eq("dados_z", ifz.o_dados_entrada, m_dados_z);
    check_eq("parar_z", 32'(ifz.o_parar), 32'(e_parar));
    check_eq("disp_z",  ifz.o_display, m_disp);
    check_eq("cnt_z",   32'(ifz.o_cont_saida), 32'(m_cnt));
    check_eq("val_z",   32'(ifz.o_saida_valida), 32'(m_valid));
    check_eq("out_z",   32'(ifz.o_out), 32'(ifa.i_saida_req));
    if (ifa.o_in) n_in++;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rand_out) begin
      ifa.i_saida_req = ($urandom_range(0, 3) == 0);
      bank_val        = $urandom;
    end
  endtask

  // Clean press now; In is due 2 sync + DEB debounce + 1 FSM cycles later
  task automatic do_press(input logic [15:0] sw);
    ifa.i_chaves = sw;
    exp_data_z   = 32'(sw);
    exp_data_s   = (sw >= 16'h8000) ? (32'(sw) - 32'h0001_0000) : 32'(sw);
    ifa.i_botao_confirma = 1'b1;
    exp_in_cyc   = cyc + 2 + DEB + 1;
    repeat (8) step();
    ifa.i_botao_confirma = 1'b0;
  endtask

  initial begin
    int n0, first_in, hold;
    logic [31:0] v;
    reset = 1'b1;
    rand_out = 1'b0;
    bank_val = 32'h0;
    exp_in_cyc = -100;
    exp_data_s = 32'h0;
    exp_data_z = 32'h0;
    ifa.i_entrada_req = 1'b0;
    ifa.i_saida_req = 1'b0;
    ifa.i_chaves = 16'h0;
    ifa.i_botao_confirma = 1'b0;
    #1;
    check_eq("rst_in", 32'(ifa.o_in), 32'h0);
    check_eq("rst_dados", ifa.o_dados_entrada, 32'h0);
    check_eq("rst_disp", ifa.o_display, 32'h0);
    check_eq("rst_valida", 32'(ifa.o_saida_valida), 32'h0);
    check_eq("rst_cont", 32'(ifa.o_cont_saida), 32'h0);
    check_eq("rst_parar0", 32'(ifa.o_parar), 32'h0);
    ifa.i_entrada_req = 1'b1;
    #1;
    check_eq("rst_parar1", 32'(ifa.o_parar), 32'h1);
    ifa.i_entrada_req = 1'b0;
    step(); step();
    reset = 1'b0;
    repeat (10) step();

    // Signed input: both sign- and zero-extending instances
    ifa.i_entrada_req = 1'b1;
    step(); step();
    do_press(16'h8005);
    // do_press returns one cycle after CONCLUI; data must still hold
    check_eq("sig_dados_s", ifa.o_dados_entrada, 32'hFFFF_8005);
    check_eq("sig_dados_z", ifz.o_dados_entrada, 32'h0000_8005);
    ifa.i_entrada_req = 1'b0;
    repeat (10) step();

    // A few captures so reset has something to clear
    repeat (3) begin
      ifa.i_saida_req = 1'b1;
      bank_val = $urandom | 32'h1;
      step();
      ifa.i_saida_req = 1'b0;
      step();
    end

    // Reset while the FSM waits on a press that is mid-debounce
    ifa.i_entrada_req = 1'b1;
    step(); step();
    ifa.i_botao_confirma = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check_eq("rmid_in", 32'(ifa.o_in), 32'h0);
    check_eq("rmid_dados", ifa.o_dados_entrada, 32'h0);
    check_eq("rmid_disp", ifa.o_display, 32'h0);
    check_eq("rmid_cont", 32'(ifa.o_cont_saida), 32'h0);
    check_eq("rmid_parar", 32'(ifa.o_parar), 32'(ifa.i_entrada_req));
    ifa.i_entrada_req = 1'b0;
    ifa.i_botao_confirma = 1'b0;
    step(); step();
    reset = 1'b0;
    repeat (10) step();

    // Output capture and counter wrap
    ifa.i_saida_req = 1'b1;
    bank_val = 32'h0000_002A;
    #1;
    check_eq("cap_out", 32'(ifa.o_out), 32'h1);
    step();
    ifa.i_saida_req = 1'b0;
    check_eq("cap_disp", ifa.o_display, 32'h0000_002A);
    check_eq("cap_valida", 32'(ifa.o_saida_valida), 32'h1);
    check_eq("cap_cont", 32'(ifa.o_cont_saida), 32'h1);
    for (int i = 0; i < 255; i++) begin
      ifa.i_saida_req = 1'b1;
      bank_val = $urandom;
      step();
    end
    check_eq("wrap_cont", 32'(ifa.o_cont_saida), 32'h0);
    ifa.i_saida_req = 1'b0;
    step();

    // Bounce shorter than the debounce window, then a stable press
    ifa.i_entrada_req = 1'b1;
    step(); step();
    n0 = n_in;
    for (int i = 0; i < 10; i++) begin
      ifa.i_botao_confirma = (i % 2 == 0);
      repeat (2) step();
    end
    do_press(16'($urandom));
    ifa.i_entrada_req = 1'b0;
    repeat (10) step();
    check_eq("bounce_npulses", 32'(n_in - n0), 32'h1);

    // Button already held when the request arrives
    ifa.i_botao_confirma = 1'b1;
    repeat (10) step();
    ifa.i_entrada_req = 1'b1;
    n0 = n_in;
    repeat (15) step();
    check_eq("held_nopulse", 32'(n_in - n0), 32'h0);
    ifa.i_botao_confirma = 1'b0;
    repeat (10) step();
    do_press(16'($urandom));
    ifa.i_entrada_req = 1'b0;
    repeat (10) step();
    check_eq("held_npulses", 32'(n_in - n0), 32'h1);

    // Simultaneous input and output requests
    ifa.i_entrada_req = 1'b1;
    ifa.i_saida_req = 1'b1;
    v = $urandom;
    bank_val = v;
    step();
    ifa.i_saida_req = 1'b0;
    check_eq("sim_disp", ifa.o_display, v);
    check_eq("sim_parar", 32'(ifa.o_parar), 32'h1);
    n0 = n_in;
    do_press(16'($urandom));
    ifa.i_entrada_req = 1'b0;
    repeat (10) step();
    check_eq("sim_npulses", 32'(n_in - n0), 32'h1);

    // Request withdrawn while waiting: a later press is ignored
    ifa.i_entrada_req = 1'b1;
    repeat (3) step();
    ifa.i_entrada_req = 1'b0;
    n0 = n_in;
    step(); step();
    ifa.i_botao_confirma = 1'b1;
    repeat (10) step();
    ifa.i_botao_confirma = 1'b0;
    repeat (10) step();
    check_eq("withdraw_nopulse", 32'(n_in - n0), 32'h0);

    // Back-to-back input instructions
    ifa.i_entrada_req = 1'b1;
    step();
    n0 = n_in;
    do_press(16'h0001);
    first_in = exp_in_cyc;
    repeat (9) step();
    do_press(16'h0002);
    check_eq("b2b_dados", ifa.o_dados_entrada, 32'h0000_0002);
    check_eq("b2b_gap", 32'(exp_in_cyc - first_in >= DEB), 32'h1);
    ifa.i_entrada_req = 1'b0;
    repeat (10) step();
    check_eq("b2b_npulses", 32'(n_in - n0), 32'h2);

    // Randomized transfers with random bounce and background output traffic
    rand_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(1, 4)) step();
      ifa.i_entrada_req = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      n0 = n_in;
      repeat ($urandom_range(0, 4)) begin
        hold = $urandom_range(1, DEB - 1);
        ifa.i_botao_confirma = 1'b1;
        repeat (hold) step();
        ifa.i_botao_confirma = 1'b0;
        repeat ($urandom_range(1, DEB - 1)) step();
      end
      do_press(16'($urandom));
      ifa.i_entrada_req = 1'b0;
      repeat (10) step();
      check_eq("rand_npulses", 32'(n_in - n0), 32'h1);
    end
    rand_out = 1'b0;
    ifa.i_saida_req = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
